// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory responder.
// Mailbox support is selected at build time with the DMEM_MAILBOX_EN macro.
package dmem_pkg;

  localparam int DMEM_ADDR_W       = 13;
  localparam int DMEM_DATA_W       = 16;
  localparam int DMEM_DEPTH        = 128;
  localparam int DMEM_MAILBOX_ADDR = 100;
  localparam int DMEM_PASS_VALUE   = 7;
  localparam int DMEM_CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised single-port RAM: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int DATA_W = DMEM_DATA_W,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with configurable wait states, range checking and an
// optional completion mailbox (build with DMEM_MAILBOX_EN to enable it).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = DMEM_ADDR_W,
  parameter int DATA_W       = DMEM_DATA_W,
  parameter int DEPTH        = DMEM_DEPTH,
  parameter int WAIT_STATES  = 0,
  parameter int MAILBOX_ADDR = DMEM_MAILBOX_ADDR,
  parameter int PASS_VALUE   = DMEM_PASS_VALUE
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ready_o,
  output logic              err_o,
  output logic              done_o,
  output logic              pass_o
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e                state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;

  logic                  bad_access;
  logic                  ram_we;
  logic [DATA_W-1:0]     ram_rdata;
  logic [DATA_W-1:0]     load_data;

  // Widen the word index to 32 bits so DEPTH == 2^(ADDR_W-1) still compares correctly.
  assign bad_access = addr_q[0] |
                      ({{(32-(ADDR_W-1)){1'b0}}, addr_q[ADDR_W-1:1]} >= 32'(DEPTH));
  assign ram_we     = (state_q == RESP) && write_q && !bad_access;
  assign load_data  = bad_access ? '0 : ram_rdata;

  dmem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .idx_i   (addr_q[IDX_W:1]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          write_d = mem_write_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = DMEM_CNT_W'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DMEM_CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (!write_q) begin
          rdata_d = load_data;
        end
        if (bad_access) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DMEM_MAILBOX_EN
  logic mbox_hit;

  assign mbox_hit = ram_we && (addr_q == ADDR_W'(MAILBOX_ADDR));
  assign done_d   = done_q | mbox_hit;
  assign pass_d   = pass_q | (mbox_hit && (wdata_q == DATA_W'(PASS_VALUE)));
`else
  logic unused_mbox_cfg;

  assign unused_mbox_cfg = ^{ADDR_W'(MAILBOX_ADDR), DATA_W'(PASS_VALUE)};
  assign done_d          = 1'b0;
  assign pass_d          = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Load data is presented live during RESP and held afterwards.
  assign rdata_o = ((state_q == RESP) && !write_q) ? load_data : rdata_q;
  assign ready_o = (state_q == RESP);
  assign err_o   = err_q;
  assign done_o  = done_q;
  assign pass_o  = pass_q;

endmodule
